// File: rtl/prog_loader_if.sv
// Program-memory write port and boot status seen by the GCD processor.
// The loader drives it as master; the processor side and the bench observe it as slave.
interface prog_loader_if;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_din;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_err;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_din,
    output cpu_hold,
    output busy,
    output load_done,
    output load_err
  );

  modport slave (
    input mem_we,
    input mem_addr,
    input mem_din,
    input cpu_hold,
    input busy,
    input load_done,
    input load_err
  );
endinterface

// File: rtl/prog_loader.sv
// UART (8N1) boot loader: receives SYNC,LEN,data,CHK frames and writes nibbles into the
// 256x4 program memory, holding the processor until a checksum-valid image has loaded.
module prog_loader #(
  parameter int         CLKS_PER_BIT   = 434,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  prog_loader_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_s3;
  logic [1:0]       r_ustate;
  logic [CNT_W-1:0] r_ucnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_stb;
  logic             r_ferr_stb;
  logic [7:0]       r_byte;

  logic [2:0]       r_state;
  logic [8:0]       r_rem;
  logic [7:0]       r_xor;
  logic [7:0]       r_data;
  logic [7:0]       r_addr;
  logic             r_hold;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [TMO_W-1:0] r_tmo;

  logic             w_rx_fall;
  logic             w_tmo_state;
  logic             w_timeout;
  logic             w_abort;

  // r_rx_s3 is only a delayed copy of the synchronised line, used for edge detection
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  // ---- UART receiver: sync, start validation, bit-centre sampling ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_ustate   <= U_IDLE;
      r_ucnt     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte_stb <= 1'b0;
      r_ferr_stb <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_byte_stb <= 1'b0;
      r_ferr_stb <= 1'b0;
      case (r_ustate)
        U_IDLE: begin
          r_ucnt <= '0;
          if (w_rx_fall) r_ustate <= U_START;
        end
        U_START: begin
          if (r_ucnt == HALF_LAST) begin
            r_ucnt    <= '0;
            r_bit_idx <= '0;
            // a start that is high again at half-bit was a glitch
            r_ustate  <= r_rx_s2 ? U_IDLE : U_DATA;
          end else begin
            r_ucnt <= r_ucnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_ucnt == BIT_LAST) begin
            r_ucnt  <= '0;
            r_shift <= {r_rx_s2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_ustate <= U_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_ucnt <= r_ucnt + 1'b1;
          end
        end
        default: begin
          if (r_ucnt == BIT_LAST) begin
            r_ucnt   <= '0;
            r_ustate <= U_IDLE;
            if (r_rx_s2) begin
              r_byte_stb <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_ferr_stb <= 1'b1;
            end
          end else begin
            r_ucnt <= r_ucnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_tmo_state = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_timeout   = w_tmo_state && !r_byte_stb && !r_ferr_stb && (r_tmo == TMO_LAST);
  assign w_abort     = r_ferr_stb || w_timeout;

  // ---- frame FSM: header, nibble writes, checksum, status ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_xor   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_hold  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      if (!w_tmo_state || r_byte_stb || r_ferr_stb) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_byte_stb && (r_byte == SYNC_BYTE)) begin
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_xor   <= '0;
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_abort) begin
            r_state <= S_ERR;
          end else if (r_byte_stb) begin
            // LEN of zero encodes a full 256-nibble image
            r_rem   <= {(r_byte == 8'd0), r_byte};
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_abort) begin
            r_state <= S_ERR;
          end else if (r_byte_stb) begin
            r_xor   <= r_xor ^ r_byte;
            r_data  <= r_byte;
            r_state <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          r_rem   <= r_rem - 1'b1;
          r_addr  <= r_addr + 1'b1;
          r_state <= (r_rem == 9'd1) ? S_CHK : S_WR_HI;
        end
        S_WR_HI: begin
          r_rem   <= r_rem - 1'b1;
          r_addr  <= r_addr + 1'b1;
          r_state <= (r_rem == 9'd1) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (w_abort) begin
            r_state <= S_ERR;
          end else if (r_byte_stb) begin
            r_state <= (r_byte == r_xor) ? S_DONE : S_ERR;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_hold  <= 1'b0;
          r_addr  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          // already-written nibbles stay; cpu_hold keeps the bad image from running
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we    = (r_state == S_WR_LO) || (r_state == S_WR_HI);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_din   = (r_state == S_WR_HI) ? r_data[7:4] : r_data[3:0];
  assign bus.cpu_hold  = r_hold;
  assign bus.busy      = r_busy;
  assign bus.load_done = r_done;
  assign bus.load_err  = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written corner sequences,
// with a write scoreboard matching expected (addr, nibble) pairs against memory writes.
module tb_prog_loader;
  localparam int CPB = 8;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  always #5 clk = ~clk;

  prog_loader_if ldr();

  prog_loader #(
    .CLKS_PER_BIT  (CPB),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (ldr)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] d;
  } wr_t;

  typedef struct {
    string      name;
    logic [7:0] len;
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] chk;
    bit         exp_done;
  } vec_t;

  wr_t        q_exp[$];
  wr_t        q_act[$];
  logic [7:0] fb[256];
  vec_t       vec[5];
  int         n_checks = 0;
  int         n_errs   = 0;

  always @(negedge clk) begin
    if (ldr.mem_we === 1'b1) q_act.push_back({ldr.mem_addr, ldr.mem_din});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic push_writes(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = fb[k / 2];
      q_exp.push_back({8'(k), (k % 2 == 1) ? b[7:4] : b[3:0]});
    end
  endtask

  task automatic compare_writes(input string nm);
    wr_t e;
    wr_t a;
    check({nm, "_nwrites"}, q_act.size(), q_exp.size());
    while (q_exp.size() > 0 && q_act.size() > 0) begin
      e = q_exp.pop_front();
      a = q_act.pop_front();
      check({nm, "_write"}, 32'(a), 32'(e));
    end
    q_exp.delete();
    q_act.delete();
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while (ldr.busy === 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_busy"}, ldr.busy, 0);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] len, input int nb,
                           input logic [7:0] chk, input bit exp_done);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    push_writes(n);
    send_byte(8'hA5, 1'b1);
    send_byte(len, 1'b1);
    for (int i = 0; i < nb; i++) send_byte(fb[i], 1'b1);
    send_byte(chk, 1'b1);
    wait_idle(nm);
    check({nm, "_done"}, ldr.load_done, exp_done);
    check({nm, "_err"},  ldr.load_err,  !exp_done);
    check({nm, "_hold"}, ldr.cpu_hold,  !exp_done);
    if (exp_done) check({nm, "_addr"}, ldr.mem_addr, 0);
    compare_writes(nm);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_we"},   ldr.mem_we,    0);
    check({nm, "_addr"}, ldr.mem_addr,  0);
    check({nm, "_din"},  ldr.mem_din,   0);
    check({nm, "_hold"}, ldr.cpu_hold,  1);
    check({nm, "_busy"}, ldr.busy,      0);
    check({nm, "_done"}, ldr.load_done, 0);
    check({nm, "_err"},  ldr.load_err,  0);
  endtask

  initial begin
    logic [7:0] x;
    int t;

    vec[0] = '{"f04",    8'h04, 2, 8'h21, 8'h43, 8'h00, 8'h62, 1'b1};
    vec[1] = '{"f03",    8'h03, 2, 8'hBA, 8'h0C, 8'h00, 8'hB6, 1'b1};
    vec[2] = '{"badchk", 8'h02, 1, 8'h21, 8'h00, 8'h00, 8'hFF, 1'b0};
    vec[3] = '{"f01",    8'h01, 1, 8'h5E, 8'h00, 8'h00, 8'h5E, 1'b1};
    vec[4] = '{"f05",    8'h05, 3, 8'h11, 8'h22, 8'h33, 8'h00, 1'b1};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    repeat (10000) @(posedge clk);
    @(negedge clk);
    check("idle_hold", ldr.cpu_hold, 1);
    check("idle_busy", ldr.busy, 0);
    check("idle_done", ldr.load_done, 0);
    check("idle_nwrites", q_act.size(), 0);

    // short low pulse must be rejected as a glitch
    @(posedge clk);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", ldr.busy, 0);
    check("glitch_nwrites", q_act.size(), 0);

    for (int v = 0; v < 5; v++) begin
      fb[0] = vec[v].d0;
      fb[1] = vec[v].d1;
      fb[2] = vec[v].d2;
      run_frame(vec[v].name, vec[v].len, vec[v].nb, vec[v].chk, vec[v].exp_done);
    end

    // timeout after header, then recovery with a good frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    @(negedge clk);
    check("tmo_busy_mid", ldr.busy, 1);
    t = 0;
    while (ldr.load_err !== 1'b1 && t < TMO + 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("tmo_err", ldr.load_err, 1);
    check("tmo_hold", ldr.cpu_hold, 1);
    check("tmo_busy", ldr.busy, 0);
    compare_writes("tmo");
    fb[0] = 8'h21;
    fb[1] = 8'h43;
    run_frame("tmo_recover", 8'h04, 2, 8'h62, 1'b1);

    // reload while running, then reset in the middle of a data byte
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("reload_hold", ldr.cpu_hold, 1);
    check("reload_busy", ldr.busy, 1);
    check("reload_done", ldr.load_done, 0);
    send_byte(8'h04, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_after", ldr.busy, 0);
    compare_writes("midrst");

    // stop bit low on a data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h21, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr_err", ldr.load_err, 1);
    check("ferr_hold", ldr.cpu_hold, 1);
    check("ferr_busy", ldr.busy, 0);
    check("ferr_done", ldr.load_done, 0);
    compare_writes("ferr");

    // full 256-nibble image
    x = 8'h00;
    for (int i = 0; i < 128; i++) begin
      fb[i] = 8'(i * 37 + 5);
      x = x ^ fb[i];
    end
    run_frame("len256", 8'h00, 128, x, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
